// File: rtl/sram_access_sequencer.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two halfword accesses, each held for WAIT_CYCLES cycles, and freezes the
// pipeline until the access completes.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   memREn, memWEn    load / store request from MEM stage (store wins if both)
//   address           word-aligned byte address
//   writeData         store data
//   readData          registered load result
//   ready             access completing this cycle, or idle with no request
//   freeze            stall all pipeline stage registers
//   sramAddr          SRAM halfword address
//   sramWData         SRAM write data
//   sramRData         SRAM read data
//   sramWeN, sramOeN  SRAM write / output enables, active-low
module sram_access_sequencer #(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               memREn,
   input  logic               memWEn,
   input  logic [31:0]        address,
   input  logic [31:0]        writeData,
   output logic [31:0]        readData,
   output logic               ready,
   output logic               freeze,
   output logic [SRAM_AW-1:0] sramAddr,
   output logic [15:0]        sramWData,
   input  logic [15:0]        sramRData,
   output logic               sramWeN,
   output logic               sramOeN
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_op_q, we_op_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic [31:0]      rdata_q, rdata_d;

   logic               req_c;
   logic               last_c;
   logic [31:0]        hw_base_c;
   logic               ready_c;
   logic               freeze_c;
   logic [SRAM_AW-1:0] sram_addr_c;
   logic [15:0]        sram_wdata_c;
   logic               sram_we_n_c;
   logic               sram_oe_n_c;

   assign req_c  = memREn | memWEn;
   assign last_c = (cnt_q == CNT_LAST);

   // Halfword index of the low half of the latched word.
   assign hw_base_c = ((addr_q - 32'(BASE_ADDR)) >> 2) << 1;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_op_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_op_q <= we_op_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state, counter and read-capture logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_op_d = we_op_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_c) begin
               we_op_d = memWEn;
               addr_d  = address;
               data_d  = writeData;
               cnt_d   = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (last_c) begin
               if (!we_op_q) rdata_d[15:0] = sramRData;
               cnt_d   = '0;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (last_c) begin
               if (!we_op_q) rdata_d[31:16] = sramRData;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // Pipeline advances on this edge; a new request is taken from IDLE.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SRAM strobes and handshake, decoded from the current state.
   always_comb begin
      ready_c      = 1'b0;
      sram_addr_c  = '0;
      sram_wdata_c = '0;
      sram_we_n_c  = 1'b1;
      sram_oe_n_c  = 1'b1;
      case (state_q)
         IDLE: ready_c = ~req_c;
         LOW: begin
            sram_addr_c  = SRAM_AW'(hw_base_c);
            sram_wdata_c = data_q[15:0];
            // Final cycle of the half releases WE while address/data stay put.
            sram_we_n_c  = ~(we_op_q & ~last_c);
            sram_oe_n_c  = we_op_q;
         end
         HIGH: begin
            sram_addr_c  = SRAM_AW'(hw_base_c | 32'd1);
            sram_wdata_c = data_q[31:16];
            sram_we_n_c  = ~(we_op_q & ~last_c);
            sram_oe_n_c  = we_op_q;
         end
         DONE: ready_c = 1'b1;
         default: ready_c = 1'b0;
      endcase
      freeze_c = req_c & ~ready_c;
   end

   assign readData  = rdata_q;
   assign ready     = ready_c;
   assign freeze    = freeze_c;
   assign sramAddr  = sram_addr_c;
   assign sramWData = sram_wdata_c;
   assign sramWeN   = sram_we_n_c;
   assign sramOeN   = sram_oe_n_c;

endmodule
